// File: rtl/diff_io_arbiter.sv
// diff_io_arbiter
// Half-duplex line arbiter for the single-wire differential link.
// Queues outgoing codes, yields the line to incoming traffic and inserts
// guard windows before (line driven idle) and after (listen) each transmit.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   trigger_in      strobe: push data_in into the TX queue
//   data_in         code to queue
//   drop_out        1-cycle pulse: push arrived while queue full, code lost
//   queue_count_out number of codes waiting
//   rx_busy_in      receiver busy (message arriving)
//   tx_busy_in      transmitter busy
//   tx_trigger_out  1-cycle start pulse to the transmitter
//   tx_data_out     code for the transmitter, valid with tx_trigger_out
//   diff_data_in    raw line input
//   rx_data_out     line to the receiver, forced high while driving
//   io_sel          1 = driving the line, 0 = listening
//   state_out       FSM state (IDLE=0, RECV=1, GUARD=2, TRANS=3)
module diff_io_arbiter #(
  parameter int DATA_WIDTH        = 26,
  parameter int QUEUE_DEPTH       = 4,
  parameter int TURNAROUND_CYCLES = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               trigger_in,
  input  logic [DATA_WIDTH-1:0]              data_in,
  output logic                               drop_out,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count_out,
  input  logic                               rx_busy_in,
  input  logic                               tx_busy_in,
  output logic                               tx_trigger_out,
  output logic [DATA_WIDTH-1:0]              tx_data_out,
  input  logic                               diff_data_in,
  output logic                               rx_data_out,
  output logic                               io_sel,
  output logic [1:0]                         state_out
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int TW = $clog2(TURNAROUND_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
  localparam logic [TW-1:0] TURN_LOAD  = TW'(TURNAROUND_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    GUARD = 2'd2,
    TRANS = 2'd3
  } state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];

  logic do_push;
  logic do_pop;

  // Fullness is judged on the registered count, so a push arriving on the
  // pop cycle of a full queue is still rejected.
  assign do_push = trigger_in && (count != FULL_COUNT);

  // The head leaves the queue on the edge that moves GUARD into TRANS; an
  // RX claim in the same cycle wins and nothing is popped.
  assign do_pop = (state == GUARD) && !rx_busy_in && (timer <= TW'(1)) &&
                  (count != '0);

  assign queue_count_out = count;
  assign state_out       = state;
  assign rx_data_out     = io_sel ? 1'b1 : diff_data_in;

  // Queue storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      timer          <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      io_sel         <= 1'b0;
      tx_trigger_out <= 1'b0;
      tx_data_out    <= '0;
      drop_out       <= 1'b0;
    end else begin
      tx_trigger_out <= 1'b0;
      drop_out       <= trigger_in && (count == FULL_COUNT);

      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      unique case (state)
        IDLE: begin
          // The timer here is the post-transmit listen window.
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end
          if (rx_busy_in) begin
            state  <= RECV;
            io_sel <= 1'b0;
            timer  <= '0;
          end else if ((count != '0) && (timer == '0)) begin
            state  <= GUARD;
            io_sel <= 1'b1;
            timer  <= TURN_LOAD;
          end
        end

        RECV: begin
          io_sel <= 1'b0;
          timer  <= '0;
          if (!rx_busy_in) begin
            state <= IDLE;
          end
        end

        GUARD: begin
          if (rx_busy_in) begin
            state  <= RECV;
            io_sel <= 1'b0;
            timer  <= '0;
          end else if (do_pop) begin
            state          <= TRANS;
            timer          <= '0;
            tx_trigger_out <= 1'b1;
            tx_data_out    <= mem[rd_ptr];
          end else if (timer != '0) begin
            timer <= timer - 1'b1;
          end
        end

        TRANS: begin
          // The transmitter cannot have reported busy yet on the trigger
          // cycle, so tx_busy_in is only trusted once the pulse has dropped.
          if (!tx_trigger_out && !tx_busy_in) begin
            state  <= IDLE;
            io_sel <= 1'b0;
            timer  <= TURN_LOAD;
          end
        end

        default: begin
          state  <= IDLE;
          io_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule
